// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative restoring divider (DIV/DIVU) feeding the HI/LO registers.
// Revision : 1.0  initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             hilo_wena
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_dvnd;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_dvnd_mag;
    logic [WIDTH-1:0] w_dvsr_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dvnd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while new quotient bits enter at the LSB.
    assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvsr};
    assign w_fits  = ~w_trial[WIDTH];

    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    assign hilo_wena = done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_dvnd     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_count    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_rem      <= '0;
                        r_quo      <= w_dvnd_mag;
                        r_dvsr     <= w_dvsr_mag;
                        r_dvnd     <= dividend;
                        r_neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= is_signed && dividend[WIDTH-1];
                        r_div_zero <= (divisor == '0);
                        r_count    <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem   <= w_fits ? w_trial : w_shift;
                    r_quo   <= {r_quo[WIDTH-2:0], w_fits};
                    r_count <= r_count + CW'(1);
                    if (r_count == c_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero bypasses sign correction so the raw dividend
                    // reaches HI in both modes.
                    if (r_div_zero) begin
                        quotient  <= '1;
                        remainder <= r_dvnd;
                    end else begin
                        quotient  <= w_q_fix;
                        remainder <= w_r_fix;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Scoreboard bench for div_unit against a $signed / % reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             hilo_wena;

    int               n_vec = 0;
    int               n_err = 0;
    int               n_done = 0;
    logic [63:0]      sb[$];

    div_unit #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .hilo_wena (hilo_wena)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Results are compared in the middle of the done cycle, where HI/LO capture.
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [63:0] e;
            n_done++;
            chk("hilo_wena", {63'd0, hilo_wena}, 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", {32'd0, quotient}, {32'd0, e[63:32]});
                chk("remainder", {32'd0, remainder}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", {63'd0, busy}, 64'd0);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        sb.push_back(model(a, b, s));
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~s;
    endtask

    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int  n;
        bit  ok;
        start_op(a, b, s);
        wait_done(n, ok);
        chk("latency", 64'(n), 64'd33);
        chk("busy_run", {63'd0, ok}, 64'd1);
        chk("busy_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n;
        bit ok;
        int d0;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {62'd0, done, hilo_wena}, 64'd0);
        chk("rst_qr", {quotient, remainder}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div(32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", {62'd0, done, hilo_wena}, 64'd0);

        run_div(32'hFFFF_FFF9, 32'h2, 1'b1);
        run_div(32'h7, 32'hFFFF_FFFE, 1'b1);
        run_div(32'h1234_5678, 32'h0, 1'b0);
        run_div(32'hFFFF_FFF9, 32'h0, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div(32'hFFFF_FFFF, 32'h1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_idle", {quotient, remainder}, {32'hFFFF_FFFF, 32'd0});

        // Start while busy is ignored; start in the done cycle chains a new run.
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd77; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, ok);
        chk("busy_ignore", {63'd0, ok}, 64'd1);
        run_div(32'd50, 32'd5, 1'b0);

        // Asynchronous abort mid-run.
        dividend = 32'd999; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        d0  = n_done;
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_qr", {quotient, remainder}, 64'd0);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(n_done), 64'(d0));
        run_div(32'd999, 32'd9, 1'b0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 15);
                4:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
